// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the fetch/data memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int BEW         = DW_DEF / 8;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and external memory bus seen by the arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    localparam int BW = DW / 8;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          f_ready;

    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          m_req;
    logic          m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          bus_err;

    // Arbiter side
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
        output f_rdata, f_ready, d_rdata, d_ready,
        output m_req, m_we, m_be, m_addr, m_wdata, bus_err
    );

    // Datapath + memory side
    modport master (
        output f_req, f_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
        input  f_rdata, f_ready, d_rdata, d_ready,
        input  m_req, m_we, m_be, m_addr, m_wdata, bus_err
    );
endinterface

// File: rtl/arb_fetch_buf.sv
// One-entry instruction buffer {valid, tag, data} with hit compare.
// Only instantiated when ARB_FETCH_BUF_EN is defined.
module arb_fetch_buf
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_tag,
    input  logic [DW-1:0] i_fill_data,
    input  logic          i_inv,
    input  logic [AW-1:0] i_addr,
    output logic          o_hit,
    output logic [DW-1:0] o_data
);
    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [DW-1:0] r_data;

    // Fill happens in FETCH and invalidate on a grant out of IDLE, so they never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_inv) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_data  <= i_fill_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_addr);
    assign o_data = r_data;
endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto a single-port memory bus.
// Optional one-entry fetch buffer enabled by defining ARB_FETCH_BUF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t    r_state, w_state_nxt;
    logic          r_m_req, r_m_we;
    logic [BW-1:0] r_m_be;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic [CW-1:0] r_wait_cnt;
    logic          r_bus_err;

    logic          w_grant_f, w_grant_d, w_hit, w_wait;
    logic [DW-1:0] w_buf_data;

`ifdef ARB_FETCH_BUF_EN
    logic w_buf_hit;

    arb_fetch_buf #(.AW(AW), .DW(DW)) u_fbuf (
        .clk        (clk),
        .rst        (rst),
        .i_fill     ((r_state == FETCH) && bus.m_ack),
        .i_fill_tag (r_m_addr),
        .i_fill_data(bus.m_rdata),
        .i_inv      (w_grant_d && bus.d_we),
        .i_addr     (bus.f_addr),
        .o_hit      (w_buf_hit),
        .o_data     (w_buf_data)
    );

    // A pending data request always goes first, even over a buffered instruction.
    assign w_hit = (r_state == IDLE) && !bus.d_req && bus.f_req && w_buf_hit;
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_f   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.d_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = DATA;
                end else if (bus.f_req && !w_hit) begin
                    w_grant_f   = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH, DATA: begin
                if (bus.m_ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Bus fields are captured at grant and frozen until the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_be    <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (w_grant_d) begin
            r_m_req   <= 1'b1;
            r_m_we    <= bus.d_we;
            r_m_be    <= bus.d_be;
            r_m_addr  <= bus.d_addr;
            r_m_wdata <= bus.d_wdata;
        end else if (w_grant_f) begin
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_be    <= '1;
            r_m_addr  <= bus.f_addr;
            r_m_wdata <= '0;
        end else if ((r_state != IDLE) && bus.m_ack) begin
            r_m_req   <= 1'b0;
        end
    end

    assign w_wait = r_m_req && !bus.m_ack;

    // Timeout only flags the hang; the transaction keeps waiting for its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_grant_d || w_grant_f)
                r_wait_cnt <= '0;
            else if (w_wait && (r_wait_cnt != CW'(TIMEOUT_CYC)))
                r_wait_cnt <= r_wait_cnt + CW'(1);
            if (w_wait && (r_wait_cnt == CW'(TIMEOUT_CYC - 1)))
                r_bus_err <= 1'b1;
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_be    = r_m_be;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.bus_err = r_bus_err;

    assign bus.f_ready = ((r_state == FETCH) && bus.m_ack) || w_hit;
    assign bus.f_rdata = w_hit ? w_buf_data : bus.m_rdata;
    assign bus.d_ready = (r_state == DATA) && bus.m_ack;
    assign bus.d_rdata = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a word-level memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arb_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } rsp_exp_t;

    bus_exp_t    q_bus[$];
    rsp_exp_t    q_f[$];
    rsp_exp_t    q_d[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] sim_mem[int unsigned];
    int          checks = 0;
    int          errors = 0;
    int          fixed_lat = 0;
    bit          no_ack = 1'b0;
    bit          fb_valid = 1'b0;
    logic [31:0] fb_tag = '0;
    logic [31:0] fb_data = '0;

    function automatic logic [31:0] init_word(int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w, logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = w[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        int unsigned w = a >> 2;
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] sim_rd(logic [31:0] a);
        int unsigned w = a >> 2;
        return sim_mem.exists(w) ? sim_mem[w] : init_word(w);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name, string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a bus request or a ready.
    task automatic monitor();
        bit       prev_req = 1'b0, prev_ack = 1'b0;
        bus_exp_t cur, e;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
                continue;
            end
            if (bus.m_req && !prev_req) begin
                if (q_bus.size() == 0) begin
                    fail_now("bus_unexpected", $sformatf("m_req rose with m_addr=%h", bus.m_addr));
                end else begin
                    e = q_bus.pop_front();
                    chk("m_addr", bus.m_addr, e.addr);
                    chk("m_we", 32'(bus.m_we), 32'(e.we));
                    if (e.we) begin
                        chk("m_be", 32'(bus.m_be), 32'(e.be));
                        chk("m_wdata", bus.m_wdata, e.wdata);
                    end
                end
                cur = '{bus.m_addr, bus.m_we, bus.m_be, bus.m_wdata};
            end else if (bus.m_req && prev_ack) begin
                fail_now("m_req_drop", "m_req still high the cycle after m_ack");
            end else if (bus.m_req) begin
                chk("m_addr_hold", bus.m_addr, cur.addr);
                chk("m_ctl_hold", {bus.m_wdata[26:0], bus.m_be, bus.m_we},
                    {cur.wdata[26:0], cur.be, cur.we});
            end
            if (bus.f_ready) begin
                if (q_f.size() == 0) fail_now("f_ready_spurious", "f_ready with nothing outstanding");
                else begin
                    r = q_f.pop_front();
                    if (r.chk) chk("f_rdata", bus.f_rdata, r.data);
                end
            end
            if (bus.d_ready) begin
                if (q_d.size() == 0) fail_now("d_ready_spurious", "d_ready with nothing outstanding");
                else begin
                    r = q_d.pop_front();
                    if (r.chk) chk("d_rdata", bus.d_rdata, r.data);
                end
            end
            prev_req = bus.m_req;
            prev_ack = bus.m_ack;
        end
    endtask

    // Memory model: acks after a latency, keeps its own storage written from the bus.
    task automatic responder();
        bit busy = 1'b0;
        int cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ack   = 1'b0;
            bus.m_rdata = $urandom();
            if (!rst) busy = 1'b0;
            else if (bus.m_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                end else if (!no_ack) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus.m_ack   = 1'b1;
                        bus.m_rdata = sim_rd(bus.m_addr);
                        if (bus.m_we)
                            sim_mem[bus.m_addr >> 2] = merge(sim_rd(bus.m_addr), bus.m_wdata, bus.m_be);
                        busy = 1'b0;
                    end
                end
            end
        end
    endtask

    // Reference model of one episode: data (if any) is served before fetch.
    task automatic expect_episode(int kind, logic [31:0] fa, logic [31:0] da, logic dwe,
                                  logic [3:0] dbe, logic [31:0] dwd);
        if (kind != 0) begin
            q_bus.push_back('{da, dwe, dbe, dwd});
            q_d.push_back('{!dwe, dwe ? 32'h0 : ref_rd(da)});
            if (dwe) begin
                ref_mem[da >> 2] = merge(ref_rd(da), dwd, dbe);
                fb_valid = 1'b0;
            end
        end
        if (kind != 1) begin
`ifdef ARB_FETCH_BUF_EN
            if (fb_valid && fb_tag == fa) begin
                q_f.push_back('{1'b1, fb_data});
            end else begin
                q_bus.push_back('{fa, 1'b0, 4'h0, 32'h0});
                q_f.push_back('{1'b1, ref_rd(fa)});
                fb_valid = 1'b1;
                fb_tag   = fa;
                fb_data  = ref_rd(fa);
            end
`else
            q_bus.push_back('{fa, 1'b0, 4'h0, 32'h0});
            q_f.push_back('{1'b1, ref_rd(fa)});
`endif
        end
    endtask

    // kind: 0 fetch only, 1 data only, 2 both in the same cycle.
    task automatic episode(int kind, logic [31:0] fa, logic [31:0] da, logic dwe,
                           logic [3:0] dbe, logic [31:0] dwd);
        int  f_cyc = -1, d_cyc = -1;
        bit  fr, dr;
        @(posedge clk);
        #1;
        expect_episode(kind, fa, da, dwe, dbe, dwd);
        bus.f_req   = (kind != 1);
        bus.f_addr  = fa;
        bus.d_req   = (kind != 0);
        bus.d_addr  = da;
        bus.d_we    = dwe;
        bus.d_be    = dbe;
        bus.d_wdata = dwd;
        for (int n = 0; n < 60 && (bus.f_req || bus.d_req); n++) begin
            @(negedge clk);
            fr = bus.f_ready && bus.f_req;
            dr = bus.d_ready && bus.d_req;
            if (fr) f_cyc = n;
            if (dr) d_cyc = n;
            @(posedge clk);
            #1;
            if (fr) bus.f_req = 1'b0;
            if (dr) bus.d_req = 1'b0;
        end
        if (bus.f_req || bus.d_req) begin
            fail_now("episode_timeout", $sformatf("kind %0d never completed", kind));
            bus.f_req = 1'b0;
            bus.d_req = 1'b0;
        end
        if (kind == 2) chk("data_before_fetch", 32'(f_cyc > d_cyc), 32'd1);
    endtask

    initial begin
        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ack = 0; bus.m_rdata = '0;
        fork
            monitor();
            responder();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", 32'(bus.m_req), 0);
        chk("rst_m_fields", {bus.m_addr[26:0], bus.m_be, bus.m_we}, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
        chk("rst_readies", {bus.bus_err, bus.f_ready, bus.d_ready}, 32'h0);
        rst = 1'b1;

        // Reset mid-DATA: outstanding load abandoned
        @(posedge clk);
        #1;
        no_ack = 1'b1;
        q_bus.push_back('{32'h80, 1'b0, 4'h0, 32'h0});
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_be = 4'hF;
        for (int n = 0; n < 10 && !bus.m_req; n++) @(negedge clk);
        chk("mid_m_req_up", 32'(bus.m_req), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_m_req", 32'(bus.m_req), 0);
        chk("mid_rst_err_rdy", {bus.bus_err, bus.d_ready, bus.f_ready}, 0);
        no_ack = 1'b0;
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Single fetch with fixed 3-cycle memory latency
        fixed_lat = 3;
        ref_mem[32'h40 >> 2] = 32'h2008_0005;
        sim_mem[32'h40 >> 2] = 32'h2008_0005;
        episode(0, 32'h40, 0, 0, 0, 0);
        fixed_lat = 0;

        // Contention: store wins, then the fetch
        episode(2, 32'h80, 32'h100, 1'b1, 4'hF, 32'hCAFE_F00D);

        // Byte store then read back the merged word
        episode(1, 0, 32'h101, 1'b1, 4'b0010, 32'h1234_5678);
        episode(1, 0, 32'h100, 1'b0, 4'hF, 0);

        // Fetch 0x40 twice, a store elsewhere, then 0x40 again
        episode(0, 32'h40, 0, 0, 0, 0);
        episode(0, 32'h40, 0, 0, 0, 0);
        episode(1, 0, 32'h1F0, 1'b1, 4'hF, 32'h0BAD_BEEF);
        episode(0, 32'h40, 0, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            episode($urandom_range(0, 2), {$urandom_range(0, 15), 2'b00},
                    $urandom_range(0, 127) * 4 + $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Timeout: memory stalls, bus_err after TO waiting cycles, late ack still completes
        @(posedge clk);
        #1;
        no_ack = 1'b1;
        expect_episode(0, 32'h400, 0, 0, 0, 0);
        bus.f_req = 1'b1; bus.f_addr = 32'h400;
        for (int n = 0; n < 10 && !bus.m_req; n++) @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        chk("bus_err_early", 32'(bus.bus_err), 0);
        @(negedge clk);
        chk("bus_err_set", 32'(bus.bus_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("m_req_held", 32'(bus.m_req), 32'd1);
        no_ack = 1'b0;
        for (int n = 0; n < 20 && !bus.f_ready; n++) @(negedge clk);
        chk("late_ack_f_ready", 32'(bus.f_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.f_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("bus_err_sticky", 32'(bus.bus_err), 32'd1);

        chk("q_bus_drained", q_bus.size(), 0);
        chk("q_f_drained", q_f.size(), 0);
        chk("q_d_drained", q_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
